// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: handshake sequencer around a one-bit-per-clock adder.
// Optional subtract path is guarded by the SERIAL_ADD_SUB_EN macro.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   in_valid   operands a, b, cin (and sub) are valid
//   in_ready   operands can be accepted (IDLE only)
//   a, b       WIDTH-bit augend and addend
//   cin        carry-in
//   sub        subtract request (only used with SERIAL_ADD_SUB_EN)
//   out_valid  result and cout are valid (DONE)
//   out_ready  consumer takes the result
//   result     WIDTH-bit sum, assembled LSB first
//   cout       final carry-out (with subtract: 1 = no borrow)
//   busy       operation in RUN or DONE
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [CW-1:0]    bitcnt;

    logic [WIDTH-1:0] b_load;
    logic             c_load;
    logic             accept;
    logic             last_bit;
    logic             s;
    logic             c_nxt;

`ifdef SERIAL_ADD_SUB_EN
    // a - b is formed as a + ~b + 1; cin has no meaning then.
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load     = b;
    assign c_load     = cin;
`endif

    assign accept   = (state == IDLE) && in_valid;
    assign last_bit = (bitcnt == LAST);

    // Full-adder bit slice on the current LSBs.
    assign s     = opa[0] ^ opb[0] ^ carry;
    assign c_nxt = (opa[0] & opb[0]) |
                   (opa[0] & carry)  |
                   (opb[0] & carry);

    // Handshake outputs decode from state only.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            opa    <= '0;
            opb    <= '0;
            carry  <= 1'b0;
            bitcnt <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            opa    <= a;
            opb    <= b_load;
            carry  <= c_load;
            bitcnt <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else if (state == RUN) begin
            carry  <= c_nxt;
            opa    <= {1'b0, opa[WIDTH-1:1]};
            opb    <= {1'b0, opb[WIDTH-1:1]};
            result <= {s, result[WIDTH-1:1]};
            // Hold at the last index so the counter never wraps.
            if (last_bit) begin
                cout <= c_nxt;
            end else begin
                bitcnt <= bitcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of serial_add_ctrl
// against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         busy;

    int total;
    int passed;
    int failed;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the full (W+1)-bit sum as plain integer arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic         c,
                                         input logic         s);
        int full;
`ifdef SERIAL_ADD_SUB_EN
        if (s) begin
            full = int'(x) + (1 << W) - int'(y);
        end else begin
            full = int'(x) + int'(y) + int'(c);
        end
`else
        full = int'(x) + int'(y) + int'(c) + 0 * int'(s);
`endif
        return (W + 1)'(full);
    endfunction

    task automatic run_op(input string        tag,
                          input logic [W-1:0] ta,
                          input logic [W-1:0] tb,
                          input logic         tcin,
                          input logic         tsub,
                          input int           stall,
                          input int           pulse,
                          input logic [W:0]   exp);
        int cnt;
        check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        cin       = tcin;
        sub       = tsub;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        sub      = 1'($urandom);
        check({tag, ".in_ready_drop"}, 32'(in_ready), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd1);
        cnt = 0;
        while (!out_valid && cnt < 4 * W) begin
            in_valid = (cnt == pulse);
            if (cnt == pulse) begin
                a = 8'h11;
            end
            tick();
            cnt++;
        end
        in_valid = 1'b0;
        check({tag, ".latency"}, 32'(cnt), 32'(W));
        check({tag, ".result"}, 32'(result), 32'(exp[W-1:0]));
        check({tag, ".cout"}, 32'(cout), 32'(exp[W]));
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".stall_result"},
                  32'({cout, result}), 32'(exp));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".out_valid_clr"}, 32'(out_valid), 32'd0);
        check({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [W:0]   exp;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic         rs;
        int           cnt;
        total     = 0;
        passed    = 0;
        failed    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.result", 32'(result), 32'd0);
        check("rst.cout", 32'(cout), 32'd0);
        rst = 1'b1;
        tick();
        check("rst.in_ready", 32'(in_ready), 32'd1);

        run_op("add35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 0, -1, 9'h07F);
        run_op("addff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 5, -1, 9'h100);
        run_op("add80_80", 8'h80, 8'h80, 1'b1, 1'b0, 0, 3, 9'h101);

        // Reset in the middle of a RUN discards the operation.
        in_valid = 1'b1;
        a        = 8'hAA;
        b        = 8'h55;
        cin      = 1'b0;
        sub      = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst.result", 32'(result), 32'd0);
        check("midrst.cout", 32'(cout), 32'd0);
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        cnt = 0;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            if (out_valid) begin
                cnt++;
            end
        end
        check("midrst.no_valid", 32'(cnt), 32'd0);
        run_op("add01_02", 8'h01, 8'h02, 1'b0, 1'b0, 0, -1, 9'h003);

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub05_07", 8'h05, 8'h07, 1'b0, 1'b1, 0, -1, 9'h0FE);
        run_op("sub07_05", 8'h07, 8'h05, 1'b0, 1'b1, 0, -1, 9'h102);
`else
        run_op("sub05_07", 8'h05, 8'h07, 1'b0, 1'b1, 0, -1, 9'h00C);
        run_op("sub07_05", 8'h07, 8'h05, 1'b0, 1'b1, 0, -1, 9'h00C);
`endif

        for (int n = 0; n < 16; n++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom);
            rs  = 1'($urandom);
            exp = model(ra, rb, rc, rs);
            run_op($sformatf("rand%0d", n), ra, rb, rc, rs,
                   int'($urandom_range(0, 3)), -1, exp);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
